// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: top-level sequencer for one row-stationary PE row.
// Latches a layer config on start, validates it, loads K weights into the
// PE row, streams one ifmap row per output row and lets the PE pipeline
// drain after each row before moving on.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   start, abort       layer start pulse (IDLE only), synchronous abort
//   cfg_kernel_size    K, kernel width
//   cfg_ifmap_width    W, ifmap row length
//   cfg_out_rows       R, number of output rows
//   ifm_ready          ifmap buffer has data this cycle
//   wgt_rd_en/addr     weight buffer read strobe and address
//   ifm_rd_en/addr     ifmap buffer read strobe (one beat) and address
//   pe_en              PE enable, one cycle after each ifmap beat
//   kernel_size        K of the last accepted config, to the PE controllers
//   busy, done, cfg_err  status: not idle / layer finished / config rejected
module conv_row_scheduler #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8,
  parameter int DRAIN_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  cfg_kernel_size,
  input  logic [CNT_WIDTH-1:0]  cfg_ifmap_width,
  input  logic [CNT_WIDTH-1:0]  cfg_out_rows,
  input  logic                  ifm_ready,
  output logic                  wgt_rd_en,
  output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
  output logic                  ifm_rd_en,
  output logic [ADDR_WIDTH-1:0] ifm_rd_addr,
  output logic                  pe_en,
  output logic [CNT_WIDTH-1:0]  kernel_size,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CFG    = 3'd1,
    S_LOAD_W = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int                   PROD_W     = ADDR_WIDTH + CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE_C      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DRAIN_LAT - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] k_q, k_d, w_q, w_d, r_q, r_d;
  logic [CNT_WIDTH-1:0] ks_q, ks_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;   // LOAD_W weight index / DRAIN cycle count
  logic [CNT_WIDTH-1:0] row_q, row_d;
  logic [CNT_WIDTH-1:0] col_q, col_d;
  logic                 pe_en_q;

  logic                 cfg_bad_s;
  logic                 beat_s;
  logic [PROD_W-1:0]    prod_s;

  assign cfg_bad_s = (k_q == '0) || (w_q == '0) || (r_q == '0) || (k_q > w_q);
  assign beat_s    = (state_q == S_RUN) && ifm_ready;
  // Full-width product so row*W never overflows before the deliberate wrap.
  assign prod_s    = PROD_W'(row_q) * PROD_W'(w_q) + PROD_W'(col_q);

  assign wgt_rd_en   = (state_q == S_LOAD_W);
  assign wgt_rd_addr = (state_q == S_LOAD_W) ? ADDR_WIDTH'(cnt_q) : '0;
  assign ifm_rd_en   = beat_s;
  assign ifm_rd_addr = (state_q == S_RUN) ? prod_s[ADDR_WIDTH-1:0] : '0;
  assign pe_en       = pe_en_q;
  assign kernel_size = ks_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign cfg_err     = (state_q == S_CFG) && cfg_bad_s;

  // Next-state and counter logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_d     = w_q;
    r_d     = r_q;
    ks_d    = ks_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          k_d     = cfg_kernel_size;
          w_d     = cfg_ifmap_width;
          r_d     = cfg_out_rows;
          state_d = S_CFG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFG: begin
        if (cfg_bad_s) begin
          state_d = S_IDLE;
        end else begin
          ks_d    = k_q;
          cnt_d   = '0;
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (cnt_q == k_q - ONE_C) begin
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_RUN: begin
        if (beat_s) begin
          if (col_q == w_q - ONE_C) begin
            col_d   = '0;
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            col_d = col_q + ONE_C;
          end
        end else begin
          col_d = col_q;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d = '0;
          if (row_q == r_q - ONE_C) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + ONE_C;
            state_d = S_RUN;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        row_d   = '0;
        col_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      row_d   = '0;
      col_d   = '0;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State, config, counter and pe_en registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      w_q     <= '0;
      r_q     <= '0;
      ks_q    <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      pe_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
      r_q     <= r_d;
      ks_q    <= ks_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pe_en_q <= beat_s;
    end
  end

endmodule

// File: tb/tb_conv_row_scheduler.sv
module tb_conv_row_scheduler;

  localparam int AW = 4;
  localparam int CW = 8;
  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start, abort, ifm_ready;
  logic [CW-1:0] cfg_kernel_size, cfg_ifmap_width, cfg_out_rows;
  logic          wgt_rd_en, ifm_rd_en, pe_en, busy, done, cfg_err;
  logic [AW-1:0] wgt_rd_addr, ifm_rd_addr;
  logic [CW-1:0] kernel_size;

  conv_row_scheduler #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .DRAIN_LAT(DL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_kernel_size(cfg_kernel_size), .cfg_ifmap_width(cfg_ifmap_width),
    .cfg_out_rows(cfg_out_rows), .ifm_ready(ifm_ready),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr),
    .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr),
    .pe_en(pe_en), .kernel_size(kernel_size),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t wq[$];
  ev_t iq[$];
  ev_t pq[$];

  int cyc = 0;
  int base = 0;
  bit mon_on = 1'b0;
  int exp_done, exp_err, busy_last;
  int n_done, n_errp;
  int ks_model = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: pops expected events whenever the DUT shows a read/enable.
  int  m_rel;
  ev_t m_e;
  always @(negedge clk) begin
    if (mon_on) begin
      m_rel = cyc - base;
      check_eq("busy", int'(busy), int'(m_rel >= 1 && m_rel <= busy_last));
      if (wgt_rd_en) begin
        if (wq.size() == 0) check_eq("wgt_extra", m_rel, -1);
        else begin
          m_e = wq.pop_front();
          check_eq("wgt_cyc", m_rel, m_e.cyc);
          check_eq("wgt_addr", int'(wgt_rd_addr), m_e.val);
        end
      end
      if (ifm_rd_en) begin
        if (iq.size() == 0) check_eq("ifm_extra", m_rel, -1);
        else begin
          m_e = iq.pop_front();
          check_eq("ifm_cyc", m_rel, m_e.cyc);
          check_eq("ifm_addr", int'(ifm_rd_addr), m_e.val);
        end
      end
      if (pe_en) begin
        if (pq.size() == 0) check_eq("pe_extra", m_rel, -1);
        else begin
          m_e = pq.pop_front();
          check_eq("pe_cyc", m_rel, m_e.cyc);
        end
      end
      if (done) begin
        n_done++;
        check_eq("done_cyc", m_rel, exp_done);
      end
      if (cfg_err) begin
        n_errp++;
        check_eq("cfg_err_cyc", m_rel, exp_err);
      end
    end
  end

  // One layer run: build expected events, drive it, then check leftovers.
  // ab_cyc > 0 aborts in that cycle; rs_cyc > 0 pulses rstn in that cycle.
  task automatic run_scn(input int k, input int w, input int r,
                         input int st_lo, input int st_hi,
                         input int ab_cyc, input int rs_cyc);
    int  t, col, rel, lim_i, lim_p;
    bit  valid;
    wq.delete(); iq.delete(); pq.delete();
    n_done = 0; n_errp = 0;
    valid = (k != 0) && (w != 0) && (r != 0) && (k <= w);
    lim_i = 1000; lim_p = 1000;
    if (ab_cyc > 0) begin lim_i = ab_cyc; lim_p = ab_cyc + 1; end
    if (rs_cyc > 0) begin lim_i = rs_cyc - 1; lim_p = rs_cyc - 1; end
    exp_done = -1;
    exp_err  = valid ? -1 : 1;
    busy_last = 1;
    if (valid) begin
      for (int i = 0; i < k; i++)
        if (2 + i <= lim_i) wq.push_back('{2 + i, i});
      t = 2 + k;
      for (int row = 0; row < r; row++) begin
        col = 0;
        while (col < w) begin
          if (!(t >= st_lo && t <= st_hi)) begin
            if (t <= lim_i) iq.push_back('{t, (row * w + col) % (1 << AW)});
            if (t + 1 <= lim_p) pq.push_back('{t + 1, 0});
            col++;
          end
          t++;
        end
        t += DL;
      end
      exp_done  = t;
      busy_last = t;
      if (ab_cyc > 0) begin exp_done = -1; busy_last = ab_cyc; end
      if (rs_cyc > 0) begin exp_done = -1; busy_last = rs_cyc - 1; end
    end

    @(posedge clk); #1;
    cfg_kernel_size = CW'(k);
    cfg_ifmap_width = CW'(w);
    cfg_out_rows    = CW'(r);
    start = 1'b1; abort = 1'b0; ifm_ready = 1'b1;
    base = cyc;
    mon_on = 1'b1;
    for (int n = 0; n < 36; n++) begin
      @(posedge clk); #1;
      rel = cyc - base;
      start     = 1'b0;
      ifm_ready = !(rel >= st_lo && rel <= st_hi);
      abort     = (rel == ab_cyc);
      if (rel == rs_cyc + 1) rstn = 1'b1;
      if (rel == rs_cyc) begin
        rstn = 1'b0;
        #1;
        check_eq("rst_outs", int'({wgt_rd_en, wgt_rd_addr, ifm_rd_en, ifm_rd_addr,
                                   pe_en, kernel_size, busy, done, cfg_err}), 0);
      end
      @(negedge clk);
      if (rel >= st_lo && rel <= st_hi) begin
        check_eq("stall_en", int'(ifm_rd_en), 0);
        check_eq("stall_addr", int'(ifm_rd_addr), 2);
      end
    end
    mon_on = 1'b0;
    abort = 1'b0;
    rstn = 1'b1;
    if (valid && rs_cyc == 0) ks_model = k;
    if (rs_cyc > 0) ks_model = 0;
    check_eq("wgt_left", wq.size(), 0);
    check_eq("ifm_left", iq.size(), 0);
    check_eq("pe_left", pq.size(), 0);
    check_eq("done_count", n_done, (exp_done >= 0) ? 1 : 0);
    check_eq("err_count", n_errp, valid ? 0 : 1);
    check_eq("kernel_size", int'(kernel_size), ks_model);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; ifm_ready = 1'b0;
    cfg_kernel_size = '0; cfg_ifmap_width = '0; cfg_out_rows = '0;
    #1;
    check_eq("reset_outs", int'({wgt_rd_en, wgt_rd_addr, ifm_rd_en, ifm_rd_addr,
                                 pe_en, kernel_size, busy, done, cfg_err}), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    run_scn(3, 8, 2, 0, -1, 0, 0);   // nominal
    run_scn(3, 8, 2, 7, 9, 0, 0);    // ifm_ready low in cycles 7-9
    run_scn(0, 8, 2, 0, -1, 0, 0);   // K=0
    run_scn(9, 8, 2, 0, -1, 0, 0);   // K>W
    run_scn(3, 8, 0, 0, -1, 0, 0);   // R=0
    run_scn(3, 8, 2, 0, -1, 8, 0);   // abort in cycle 8
    run_scn(3, 8, 2, 0, -1, 0, 0);   // full run after abort

    // abort and start together in IDLE: start is dropped
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_eq("abort_idle_busy", int'(busy), 0);

    run_scn(1, 12, 2, 0, -1, 0, 0);  // address wrap at 2^AW
    run_scn(3, 8, 2, 0, -1, 0, 7);   // reset pulse during RUN
    run_scn(3, 8, 2, 0, -1, 0, 0);   // full run after reset

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_row_scheduler.md
Name: conv_row_scheduler

Overview:
- Top-level sequencer for one row-stationary PE row.
- Latches a layer config, loads K weights into the PE row, streams one ifmap row per output row, and waits for the PE pipeline to drain.
- Drives pe_en and kernel_size into the per-PE controllers.
- Sits between the global buffer read ports and the PE row.

Parameters:
ADDR_WIDTH, 10, width of weight/ifmap buffer read addresses
CNT_WIDTH, 8, width of config fields and internal counters
DRAIN_LAT, 2, cycles spent in DRAIN after the last ifmap beat of a row (PE pipeline depth)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  pulse; begin a layer (ignored unless IDLE)
abort  in  1  synchronous; return to IDLE next edge
cfg_kernel_size  in  CNT_WIDTH  K, kernel width
cfg_ifmap_width  in  CNT_WIDTH  W, ifmap row length
cfg_out_rows  in  CNT_WIDTH  R, output rows to produce
ifm_ready  in  1  ifmap buffer has data this cycle
wgt_rd_en  out  1  weight buffer read strobe
wgt_rd_addr  out  ADDR_WIDTH  weight read address
ifm_rd_en  out  1  ifmap read strobe (a "beat" when high)
ifm_rd_addr  out  ADDR_WIDTH  ifmap read address
pe_en  out  1  enable to PE controllers
kernel_size  out  CNT_WIDTH  latched K to PE controllers
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, layer finished
cfg_err  out  1  one-cycle pulse, config rejected

Behaviour:
- Reset (rstn low, async):
  - state=IDLE; all counters and addresses cleared.
  - Every output is 0, including kernel_size.
- States: IDLE, CFG, LOAD_W, RUN, DRAIN, DONE. The state register is the only source of Moore outputs.
- IDLE:
  - On start=1, latch K, W and R, then go to CFG.
  - start in any other state has no effect.
- CFG: one cycle. Validates the latched config:
  - If K==0, W==0, R==0 or K>W: assert cfg_err for this cycle and go to IDLE. No reads are issued and kernel_size is not updated.
  - Otherwise drive kernel_size=K (held until the next valid CFG) and go to LOAD_W.
- LOAD_W:
  - Exactly K cycles.
  - wgt_rd_en=1; wgt_rd_addr=0,1,…,K-1 on successive cycles.
  - Not stalled by ifm_ready.
  - Exits to RUN with row=0 and col=0.
- RUN:
  - ifm_rd_en = ifm_ready. This is the only input-to-output combinational path.
  - ifm_rd_addr = row*W + col, truncated modulo 2^ADDR_WIDTH (wraps, no error).
  - col increments only on a beat. When ifm_ready=0, col and addr hold.
  - After the beat with col==W-1: go to DRAIN and clear col.
- DRAIN:
  - Exactly DRAIN_LAT cycles; no reads.
  - Then, if row==R-1, go to DONE. Otherwise row++ and go to RUN.
  - Weights are not reloaded between rows.
- pe_en: registered copy of ifm_rd_en, so it is high one cycle after each beat, aligned with SRAM read data. It is 0 in all other cycles.
- DONE: done=1 for one cycle, then go to IDLE.
- busy is 1 in CFG, LOAD_W, RUN, DRAIN and DONE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; counters clear; no done.
  - pe_en may still show one trailing cycle from a beat in the abort cycle.
  - Abort has priority over all other transitions.
  - abort in IDLE is a no-op. abort and start together in IDLE: abort wins and start is dropped.
- Reset mid-operation: immediate return to the reset values above; no done and no cfg_err.
- Counter widths: row and col are CNT_WIDTH. The address multiply is done at ADDR_WIDTH+CNT_WIDTH bits, then truncated.

Test Plan:
- K=3, W=8, R=2, ifm_ready=1, start sampled at edge 0:
  - CFG at cycle 1.
  - wgt_rd_addr 0,1,2 in cycles 2-4.
  - ifm_rd_addr 0..7 in cycles 5-12; DRAIN in cycles 13-14.
  - ifm_rd_addr 8..15 in cycles 15-22.
  - done=1 in cycle 25; busy falls in cycle 26.
  - pe_en high in cycles 6-13 and 16-23.
- Same config with ifm_ready=0 in cycles 7-9: ifm_rd_en=0 and addr held at 2 for those cycles; row 0 finishes 3 cycles later; 16 beats total; done in cycle 28.
- Bad configs, each checked separately: K=0; K=9 with W=8; R=0. Each gives cfg_err=1 at cycle 1, no wgt/ifm reads, no done, and kernel_size keeps its previous value.
- abort asserted at cycle 8 of the first scenario: IDLE at cycle 9, busy=0, no done; a new start then runs the full first scenario correctly.
- ADDR_WIDTH=4, K=1, W=12, R=2: second-row addresses are 12,13,14,15,0,1,…,7 (wrap), and done asserts.
- rstn pulsed low during RUN: all outputs are 0 asynchronously; start after release behaves as in the first scenario.
